// File: rtl/bus_txn_pkg.sv
// Shared types and constants for the bus transaction scheduler.
// State codes are visible on the debug port, so their encodings are fixed.
package bus_txn_pkg;
    localparam int DATA_W  = 8;
    localparam int STATE_W = 3;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_THINK    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT     = 3'd4,
        ST_GET_ACK  = 3'd5,
        ST_WAIT_BUS = 3'd6
    } state_t;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = i[IDX_W-1:0];
        return idx;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr wins.
// The request vector is rotated so ptr lands at bit 0, the lowest set bit is isolated, then rotated back.
module rr_arbiter
    import bus_txn_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        rot    = NUM_REQ'({req, req} >> ptr);
        pick   = rot & (~rot + 1'b1);
        winner = NUM_REQ'(({pick, pick} << ptr) >> NUM_REQ);
    end
endmodule

// File: rtl/bus_txn_sched.sv
// Bus transaction scheduler: arbitrates requesters, then runs one
// bus read / think / send / ack sequence on behalf of the winner.
module bus_txn_sched
    import bus_txn_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int THINK_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               bus_req,
    input  logic               bus_gnt,
    output logic               rd_en,
    input  logic               rd_valid,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               tx_valid,
    output logic [DATA_W-1:0]  tx_data,
    input  logic               tx_ready,
    input  logic               ack,
    output logic [NUM_REQ-1:0] done,
    output logic               err,
    output logic [STATE_W-1:0] state
);
    state_t              cur_st, nxt_st;
    logic [IDX_W-1:0]    ptr, win_idx;
    logic [NUM_REQ-1:0]  winner;
    logic [DATA_W-1:0]   data_q;
    logic [7:0]          cnt;
    logic                rd_seen;
    logic                think_done, ack_expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    // cnt restarts at 0 on every state change, so it is the dwell time in the current state
    assign think_done  = (cnt == 8'(THINK_CYCLES - 1));
    assign ack_expired = (cnt == 8'(ACK_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cur_st  <= ST_IDLE;
            ptr     <= '0;
            win_idx <= '0;
            grant   <= '0;
            data_q  <= '0;
            cnt     <= '0;
            rd_seen <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
        end else begin
            cur_st  <= nxt_st;
            cnt     <= (nxt_st != cur_st) ? 8'd0 : cnt + 8'd1;
            rd_seen <= (cur_st == ST_READ);
            done    <= '0;
            err     <= 1'b0;
            if (cur_st == ST_IDLE && |req) begin
                grant   <= winner;
                win_idx <= oh2idx(MAX_REQ'(winner));
            end
            if (cur_st == ST_READ && rd_valid)
                data_q <= rd_data;
            // ack takes precedence when it lands on the timeout cycle
            if (cur_st == ST_GET_ACK && (ack || ack_expired)) begin
                grant <= '0;
                ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                if (ack) done <= grant;
                else     err  <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_st = cur_st;
        unique case (cur_st)
            ST_IDLE:     if (|req)                 nxt_st = ST_WAIT_BUS;
            ST_WAIT_BUS: if (bus_gnt)              nxt_st = ST_READ;
            ST_READ:     if (rd_valid)             nxt_st = ST_THINK;
            ST_THINK:    if (think_done)           nxt_st = ST_SEND;
            ST_SEND:     if (tx_ready)             nxt_st = ST_WAIT;
            ST_WAIT:                               nxt_st = ST_GET_ACK;
            ST_GET_ACK:  if (ack || ack_expired)   nxt_st = ST_IDLE;
            default:                               nxt_st = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req  = (cur_st != ST_IDLE);
        rd_en    = (cur_st == ST_READ) && !rd_seen;
        tx_valid = (cur_st == ST_SEND);
        tx_data  = tx_valid ? data_q : '0;
        state    = cur_st;
    end
endmodule

// File: tb/tb_bus_txn_sched.sv
// Directed bench for bus_txn_sched: expected done/err outcomes are queued per
// transaction and retired by a monitor when the DUT pulses done or err.
module tb_bus_txn_sched;
    import bus_txn_pkg::*;

    localparam int NREQ = 4;
    localparam int THINK = 2;
    localparam int TMO = 15;

    logic            clk, reset_L;
    logic [NREQ-1:0] req, grant, done;
    logic            bus_req, bus_gnt, rd_en, rd_valid, tx_valid, tx_ready, ack, err;
    logic [7:0]      rd_data, tx_data;
    logic [2:0]      state;

    typedef struct {
        logic [NREQ-1:0] grant;
        bit              is_err;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bus_txn_sched #(.NUM_REQ(NREQ), .THINK_CYCLES(THINK), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_L(reset_L), .req(req), .grant(grant), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .ack(ack),
        .done(done), .err(err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, state, ST_IDLE);
        chk({tag, "_outs"}, {grant, bus_req, rd_en, tx_valid, tx_data, done, err}, 0);
    endtask

    // Runs one transaction starting at a negedge; ack_cyc==0 means never ack.
    task automatic run_txn(input logic [3:0] r, input logic [3:0] gexp, input logic [7:0] d,
                           input int gnt_dly, input int rd_dly, input int rdy_dly,
                           input int ack_cyc, input bit drop, input bit abort);
        int n;
        txn_t t;
        if (!abort) begin
            t.grant  = gexp;
            t.is_err = (ack_cyc == 0);
            sb.push_back(t);
        end
        req = r;
        wait_state(ST_WAIT_BUS, "enter_wait_bus");
        chk("grant", grant, gexp);
        chk("bus_req_wb", bus_req, 1);
        if (drop) req = '0;
        repeat (gnt_dly) begin
            @(negedge clk);
            chk("hold_wait_bus", state, ST_WAIT_BUS);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("enter_read", state, ST_READ);
        chk("rd_en_first", rd_en, 1);
        repeat (rd_dly) begin
            @(negedge clk);
            chk("rd_en_later", {state, rd_en}, {ST_READ, 1'b0});
        end
        rd_valid = 1'b1;
        rd_data  = d;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_data  = ~d;
        chk("enter_think", state, ST_THINK);
        if (abort) begin
            reset_L = 1'b0;
            @(negedge clk);
            chk_quiet("abort");
            reset_L = 1'b1;
            return;
        end
        n = 0;
        while (state === ST_THINK && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("think_len", n, THINK);
        chk("enter_send", state, ST_SEND);
        chk("tx_first", {tx_valid, tx_data}, {1'b1, d});
        repeat (rdy_dly) begin
            tx_ready = 1'b0;
            ack      = 1'b1;
            bus_gnt  = 1'b1;
            rd_data  = 8'($urandom);
            @(negedge clk);
            chk("tx_hold", {state, tx_valid, tx_data}, {ST_SEND, 1'b1, d});
        end
        ack      = 1'b0;
        bus_gnt  = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("enter_wait", {state, tx_valid}, {ST_WAIT, 1'b0});
        @(negedge clk);
        chk("enter_get_ack", state, ST_GET_ACK);
        chk("bus_req_ga", bus_req, 1);
        chk("grant_held", grant, gexp);
        if (ack_cyc > 0) begin
            for (int k = 1; k <= ack_cyc; k++) begin
                if (k > 1) chk("in_get_ack", state, ST_GET_ACK);
                if (k == ack_cyc) ack = 1'b1;
                @(negedge clk);
            end
            ack = 1'b0;
        end else begin
            n = 0;
            while (state === ST_GET_ACK && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_len", n, TMO + 1);
            chk("err_at_timeout", {err, done}, {1'b1, 4'b0});
        end
        chk("back_idle", {state, grant, bus_req}, {ST_IDLE, 4'b0, 1'b0});
    endtask

    always @(negedge clk) begin
        if (done !== '0 || err !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {done, err}, 0);
            end else begin
                txn_t t;
                t = sb.pop_front();
                chk("done", done, t.is_err ? 4'b0 : t.grant);
                chk("err", err, t.is_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog state %0d exp completion", state);
        $fatal(1);
    end

    initial begin
        reset_L = 1'b0; req = '0; bus_gnt = 0; rd_valid = 0; rd_data = '0;
        tx_ready = 0; ack = 0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset_L = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset_idle");

        // four back-to-back with all requesting: strict rotation from 0
        run_txn(4'b1111, 4'b0001, 8'h11, 0, 0, 0, 1, 0, 0);
        run_txn(4'b1111, 4'b0010, 8'h22, 1, 1, 0, 2, 0, 0);
        run_txn(4'b1111, 4'b0100, 8'h33, 0, 0, 1, 1, 0, 0);
        run_txn(4'b1111, 4'b1000, 8'h44, 0, 0, 0, 1, 0, 0);
        // ptr back at 0: 0110 picks requester 1, ptr moves to 2
        run_txn(4'b0110, 4'b0010, 8'hA5, 2, 0, 0, 3, 0, 0);
        // ptr 2 -> requester 2; stalled send with spurious ack, ack on timeout cycle, req dropped
        run_txn(4'b1111, 4'b0100, 8'h5C, 0, 2, 5, TMO + 1, 1, 0);
        // ptr 3, only requester 0: wraps; ack never comes
        run_txn(4'b0001, 4'b0001, 8'hE7, 1, 0, 0, 0, 0, 0);
        // ptr 1 -> requester 1, reset during THINK
        run_txn(4'b1111, 4'b0010, 8'h99, 0, 0, 0, 1, 0, 1);
        // reset restored ptr to 0
        run_txn(4'b1111, 4'b0001, 8'h3C, 0, 0, 0, 1, 0, 0);

        req = '0;
        repeat (3) @(negedge clk);
        chk_quiet("final_idle");
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
